// File: rtl/vec_store_seq.sv
// Splits one latched 128-bit vector into up to four masked word writes; write n lands n cycles after accept, done follows the last.
// A mem_ready stall freezes the current beat; no new vector is accepted until the done cycle has passed.
module vec_store_seq #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [15:0]       in_mask,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic [127:0]        data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         mask_q, mask_d;
    logic [2:0]          nb;
    logic                wr;

    // Lowest beat at or above 'from' whose mask nibble is nonzero; 4 means none left.
    function automatic logic [2:0] next_beat(input logic [15:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = 3'd4;
        for (int b = 3; b >= 0; b--) begin
            if (b >= int'(from) && m[4*b +: 4] != 4'h0) begin
                r = 3'(b);
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        data_d  = data_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        nb      = 3'd4;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d = in_data;
                    addr_d = in_addr;
                    mask_d = in_mask;
                    nb     = next_beat(in_mask, 3'd0);
                    if (nb[2]) begin
                        state_d = S_DONE;
                        k_d     = 2'd0;
                    end else begin
                        state_d = S_WRITE;
                        k_d     = nb[1:0];
                    end
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    nb = next_beat(mask_q, {1'b0, k_q} + 3'd1);
                    if (nb[2]) begin
                        state_d = S_DONE;
                    end else begin
                        k_d = nb[1:0];
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
            data_q  <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
        end
    end

    // Outputs are forced quiet while rst is held, even before the first reset edge.
    assign wr        = (state_q == S_WRITE) && !rst;
    assign mem_we    = wr;
    assign mem_addr  = wr ? addr_q + ADDR_W'(k_q) : '0;
    assign mem_wdata = wr ? data_q[32*k_q +: 32] : 32'h0;
    assign mem_be    = wr ? mask_q[4*k_q +: 4] : 4'h0;
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE) && !rst;
    assign done      = (state_q == S_DONE) && !rst;

endmodule
